// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: one full-subtractor cell and one borrow flop,
// producing in_a - in_b - borrow_in LSB first under a start/busy/done handshake.
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] sr_next;
    logic             last_bit;

    // Operands shift right each step, so bit [cnt] of the captured value
    // always sits at position 0.
    always_comb begin
        a_bit    = a_q[0];
        b_bit    = b_q[0];
        d_bit    = a_bit ^ b_bit ^ br_q;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        sr_next  = {d_bit, sr_q[WIDTH-1:1]};
        last_bit = (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            br_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out        <= '0;
            borrow_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        br_q  <= borrow_in;
                        sr_q  <= '0;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_next;
                    sr_q  <= sr_next;
                    cnt_q <= cnt_q + CW'(1);
                    // Result is published in one step from the final shift.
                    if (last_bit) begin
                        out        <= sr_next;
                        borrow_out <= br_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: cycle model of the
// handshake plus directed vectors with literal expectations.
module tb_serial_subtractor_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         borrow_out;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_a       (in_a),
        .in_b       (in_b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .out        (out),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model: an accepted start yields a result exactly W edges later.
    logic         m_busy;
    logic         m_done;
    logic [W-1:0] m_out;
    logic         m_bo;
    logic [W-1:0] p_out;
    logic         p_bo;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_bo   <= 1'b0;
            p_out  <= '0;
            p_bo   <= 1'b0;
            m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_out  <= p_out;
                m_bo   <= p_bo;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                p_out  <= W'(int'(in_a) - int'(in_b) - int'(borrow_in));
                p_bo   <= (int'(in_a) < int'(in_b) + int'(borrow_in));
                m_left <= W;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("out", int'(out), int'(m_out));
        chk("borrow_out", int'(borrow_out), int'(m_bo));
    end

    task automatic go(input int a, input int b, input int bin);
        @(negedge clk);
        in_a = W'(a);
        in_b = W'(b);
        borrow_in = bin[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) return;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk({name, " timeout"}, 0, 1);
    endtask

    task automatic run_op(input string name, input int a, input int b,
                          input int bin, input int e_out, input int e_bo);
        int bc;
        go(a, b, bin);
        wait_done(name, bc);
        chk({name, " out"}, int'(out), e_out);
        chk({name, " bo"}, int'(borrow_out), e_bo);
    endtask

    initial begin
        int bc;
        int pulses;
        int t1;
        int t2;
        #2;
        chk("reset busy", int'(busy), 0);
        chk("reset out", int'(out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: 9-3, busy for exactly 4 cycles
        go(9, 3, 0);
        wait_done("t1", bc);
        chk("t1 out", int'(out), 6);
        chk("t1 bo", int'(borrow_out), 0);
        chk("t1 busy cycles", bc, 4);

        // 2, 3: underflow and edge values
        run_op("t2", 3, 9, 0, 'hA, 1);
        run_op("t3a", 0, 0, 1, 'hF, 1);
        run_op("t3b", 15, 15, 0, 0, 0);
        run_op("t3c", 15, 0, 1, 14, 0);

        // 4: start held during RUN is ignored
        @(negedge clk);
        in_a = 4'd7; in_b = 4'd2; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        in_a = 4'd1; in_b = 4'd1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("t4 pulses", pulses, 1);
        chk("t4 out", int'(out), 5);

        // 5: back-to-back, second start applied in DONE cycle
        @(negedge clk);
        in_a = 4'd8; in_b = 4'd1; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5a", bc);
        t1 = cyc;
        chk("t5a out", int'(out), 7);
        in_a = 4'd2; in_b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5 hold", int'(out), 7);
        wait_done("t5b", bc);
        t2 = cyc;
        chk("t5 spacing", t2 - t1, 5);
        chk("t5b out", int'(out), 'hD);
        chk("t5b bo", int'(borrow_out), 1);

        // 6: asynchronous reset mid-RUN
        go(9, 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 busy", int'(busy), 0);
        chk("t6 done", int'(done), 0);
        chk("t6 out", int'(out), 0);
        chk("t6 bo", int'(borrow_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("t6 no pulse", pulses, 0);
        run_op("t6b", 6, 6, 0, 0, 0);

        // 7: exhaustive sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run_op("sweep", a, b, c, (a - b - c) & 15,
                           (a < b + c) ? 1 : 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
